// File: rtl/int8_mac_instr_pkg.sv
// int8_mac_instr_pkg
//   Shared constants and types for the int8 MAC coprocessor blocks.
//   ResultQueueDepth / ResultQueueSlack size the result queue that sits
//   behind int8_mac_unit. rq_state_e names the occupancy classes of that
//   queue; they are derived from the fill level rather than stored.
package int8_mac_instr_pkg;

    localparam int ResultQueueDepth = 4;
    localparam int ResultQueueSlack = 1;

    typedef enum logic [1:0] {
        RQ_EMPTY  = 2'd0,
        RQ_ACTIVE = 2'd1,
        RQ_FULL   = 2'd2
    } rq_state_e;

endpackage

// File: rtl/int8_mac_result_fifo.sv
// int8_mac_result_fifo
//   Generic circular FIFO storage: entry array, read/write pointers and a
//   fill level. The caller guarantees that push is only raised when there is
//   room (or when a pop happens in the same cycle).
// Ports
//   clk, rst_n     clock, async active-low reset (pointers and level only)
//   push, wdata    write wdata at the write pointer
//   pop            advance the read pointer
//   rdata          entry at the read pointer (not valid while empty)
//   level          current occupancy
//   level_next     occupancy after this cycle's push/pop
//   full, empty    level == DEPTH / level == 0
import int8_mac_instr_pkg::*;

module int8_mac_result_fifo #(
    parameter int  DEPTH   = ResultQueueDepth,
    parameter type entry_t = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] level_next,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Storage is not reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            level <= level_next;
        end
    end

    assign rdata = mem[rptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/int8_mac_result_queue.sv
// int8_mac_result_queue
//   Buffers int8_mac_unit results and presents them on the CVXIF result
//   channel with a valid/ready handshake. Because the MAC unit cannot be
//   stalled, issue_ok_o tells the decoder to stop issuing while fewer than
//   SLACK+1 free entries remain.
// Optional feature
//   INT8_MAC_RESULT_BYPASS_EN: when the queue is empty and the core is ready,
//   an incoming result goes straight to out_* in the same cycle.
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   in_*                   result from the MAC unit (in_valid_i = push)
//   issue_ok_o             decoder may accept a new instruction
//   out_valid_o/ready_i    result handshake; out_* show the head entry
//   level_o                current occupancy
//   ovf_count_o            saturating count of accepted results with overflow
//   drop_err_o             sticky: a push arrived while full and not popping
import int8_mac_instr_pkg::*;

module int8_mac_result_queue #(
    parameter int  XLEN     = 32,
    parameter int  DEPTH    = ResultQueueDepth,
    parameter int  SLACK    = ResultQueueSlack,
    parameter int  CNT_W    = 16,
    parameter type hartid_t = logic,
    parameter type id_t     = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    input  logic [XLEN-1:0]        in_data_i,
    input  logic [4:0]             in_rd_i,
    input  logic                   in_we_i,
    input  hartid_t                in_hartid_i,
    input  id_t                    in_id_i,
    input  logic                   in_overflow_i,
    output logic                   issue_ok_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        out_data_o,
    output logic [4:0]             out_rd_o,
    output logic                   out_we_o,
    output hartid_t                out_hartid_o,
    output id_t                    out_id_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [CNT_W-1:0]       ovf_count_o,
    output logic                   drop_err_o
);

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            we;
        hartid_t         hartid;
        id_t             id;
    } entry_t;

    rq_state_e              state;
    entry_t                 wdata;
    entry_t                 rdata;
    logic [$clog2(DEPTH):0] level;
    logic [$clog2(DEPTH):0] level_next;
    logic                   full;
    logic                   empty;
    logic                   fifo_valid;
    logic                   bypass;
    logic                   push;
    logic                   pop;
    logic                   accepted;
    logic                   drop;

    assign wdata = '{data: in_data_i, rd: in_rd_i, we: in_we_i,
                     hartid: in_hartid_i, id: in_id_i};

    int8_mac_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .push       (push),
        .wdata      (wdata),
        .pop        (pop),
        .rdata      (rdata),
        .level      (level),
        .level_next (level_next),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        state = RQ_ACTIVE;
        if (empty) begin
            state = RQ_EMPTY;
        end else if (full) begin
            state = RQ_FULL;
        end
    end

`ifdef INT8_MAC_RESULT_BYPASS_EN
    // Gated with rst_ni so that out_* stay at zero while reset is held.
    assign bypass = (state == RQ_EMPTY) && in_valid_i && out_ready_i && rst_ni;
`else
    assign bypass = 1'b0;
`endif

    // A push into a full queue is still legal when the head leaves this cycle.
    assign fifo_valid = (state != RQ_EMPTY);
    assign pop        = fifo_valid && out_ready_i;
    assign push       = in_valid_i && !bypass && ((state != RQ_FULL) || pop);
    assign accepted   = push || bypass;
    assign drop       = in_valid_i && (state == RQ_FULL) && !pop;

    // Outputs are forced to zero while nothing is presented, so stale
    // storage never shows and reset clears them immediately.
    always_comb begin
        out_valid_o  = fifo_valid || bypass;
        out_data_o   = '0;
        out_rd_o     = '0;
        out_we_o     = 1'b0;
        out_hartid_o = '0;
        out_id_o     = '0;
        if (bypass) begin
            out_data_o   = in_data_i;
            out_rd_o     = in_rd_i;
            out_we_o     = in_we_i;
            out_hartid_o = in_hartid_i;
            out_id_o     = in_id_i;
        end else if (fifo_valid) begin
            out_data_o   = rdata.data;
            out_rd_o     = rdata.rd;
            out_we_o     = rdata.we;
            out_hartid_o = rdata.hartid;
            out_id_o     = rdata.id;
        end
    end

    // issue_ok_o is computed from the next level so the decoder sees the
    // throttle in the cycle right after the push that consumed the margin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_ok_o  <= 1'b1;
            ovf_count_o <= '0;
            drop_err_o  <= 1'b0;
        end else begin
            issue_ok_o <= (int'(level_next) + SLACK < DEPTH);
            if (accepted && in_overflow_i && (ovf_count_o != '1)) begin
                ovf_count_o <= ovf_count_o + 1'b1;
            end
            if (drop) begin
                drop_err_o <= 1'b1;
            end
        end
    end

    assign level_o = level;

endmodule
